// File: rtl/clock_divider_n.sv
// clock_divider_n: 50%-duty programmable clock divider, any N >= 2 (odd or even).
// Divisor changes apply only at period boundaries, so clk_o never glitches.
// Optional macro CLOCK_DIVIDER_N_PHASE_OUT_EN adds phase_o (current count in period).
module clock_divider_n #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DIV_DEFAULT = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             div_load_i,
  output logic             clk_o,
  output logic             tick_o,
  output logic             div_ack_o,
  output logic             div_err_o
`ifdef CLOCK_DIVIDER_N_PHASE_OUT_EN
  ,
  output logic [DIV_W-1:0] phase_o
`endif
);

  localparam int unsigned HW = DIV_W + 1;
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DIV_DEFAULT);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             pos_q, pos_d;
  logic             neg_q;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             load_ok;
  logic             boundary;
  logic             start;
  logic [HW-1:0]    half_w;
  logic [HW-1:0]    cnt_nxt_w;

  // Half-period and next count, widened so div_q = 2^DIV_W-1 cannot overflow
  assign half_w    = (HW'(div_q) + HW'(1)) >> 1;
  assign cnt_nxt_w = HW'(cnt_q) + HW'(1);
  assign boundary  = (cnt_q == (div_q - DIV_W'(1)));

  // Next-state: phase counting, period start/stop, divisor loading
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    pos_d    = pos_q;
    tick_d   = 1'b0;
    ack_d    = 1'b0;
    start    = 1'b0;

    load_ok = div_load_i && (div_i >= DIV_W'(2));
    err_d   = div_load_i && !load_ok;

    // A valid load always lands in pending (last wins); a same-edge start consumes it
    if (load_ok) begin
      pend_d   = div_i;
      pend_v_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        pos_d = 1'b0;
        if (en_i) begin
          start = 1'b1;
        end
      end
      RUN: begin
        if (!boundary) begin
          cnt_d = cnt_q + DIV_W'(1);
          pos_d = (cnt_nxt_w < half_w);
        end else if (!en_i) begin
          state_d = IDLE;
          cnt_d   = '0;
          pos_d   = 1'b0;
        end else begin
          start = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Period start: swap in a pending divisor, then restart the high phase
    if (start) begin
      if (pend_v_d) begin
        div_d    = pend_d;
        ack_d    = 1'b1;
        pend_v_d = 1'b0;
      end
      state_d = RUN;
      cnt_d   = '0;
      pos_d   = 1'b1;
      tick_d  = 1'b1;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= DIV_RST;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      pos_q    <= 1'b0;
      tick_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      pos_q    <= pos_d;
      tick_q   <= tick_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  // Half-cycle delayed copy of pos_q, trims odd divisors to 50% duty
  always_ff @(negedge clk_i) begin
    if (reset_i) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  // Odd divisors AND in the delayed copy; even divisors use pos_q directly
  assign clk_o     = div_q[0] ? (pos_q & neg_q) : pos_q;
  assign tick_o    = tick_q;
  assign div_ack_o = ack_q;
  assign div_err_o = err_q;

`ifdef CLOCK_DIVIDER_N_PHASE_OUT_EN
  assign phase_o = cnt_q;
`endif

endmodule

// File: tb/tb_clock_divider_n.sv
// Self-checking bench for clock_divider_n: period/duty table, directed corner
// sequences and random stimulus against a half-cycle position model.
module tb_clock_divider_n;

  localparam int unsigned DIV_W = 8;

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b1;
  logic             en_i = 1'b0;
  logic [DIV_W-1:0] div_i = '0;
  logic             div_load_i = 1'b0;
  logic             clk_o;
  logic             tick_o;
  logic             div_ack_o;
  logic             div_err_o;
`ifdef CLOCK_DIVIDER_N_PHASE_OUT_EN
  logic [DIV_W-1:0] phase_o;
`endif

  clock_divider_n #(
    .DIV_W      (DIV_W),
    .DIV_DEFAULT(3)
  ) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .en_i      (en_i),
    .div_i     (div_i),
    .div_load_i(div_load_i),
    .clk_o     (clk_o),
    .tick_o    (tick_o),
    .div_ack_o (div_ack_o),
    .div_err_o (div_err_o)
`ifdef CLOCK_DIVIDER_N_PHASE_OUT_EN
    ,
    .phase_o   (phase_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: running flag, position in period, divisor, pending load
  bit m_run;
  int m_p;
  int m_n;
  int m_pend;
  bit m_pend_v;
  bit m_tick, m_ack, m_err;

  int ack_cnt = 0;
  int err_cnt = 0;
  int tick_cnt = 0;

  bit  meas_on = 1'b0;
  time rises[$];
  time falls[$];

  always @(posedge clk_o) if (meas_on) rises.push_back($time);
  always @(negedge clk_o) if (meas_on) falls.push_back($time);

  typedef struct {
    int div;
    int hi_ns;
    int per_ns;
  } vec_t;

  vec_t tbl[8];

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // clk_o from position: half-cycle index h = 2p + half.
  // Even N: high for h in [0, N-1]; odd N: high for h in [1, N].
  function automatic logic exp_clk(input int half);
    int h;
    if (!m_run) return 1'b0;
    h = 2 * m_p + half;
    if ((m_n % 2) == 1) return (h >= 1 && h <= m_n);
    return (h < m_n);
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic l, input int d);
    bit start;
    bit stop;
    if (r) begin
      m_run = 0; m_p = 0; m_n = 3; m_pend = 0; m_pend_v = 0;
      m_tick = 0; m_ack = 0; m_err = 0;
      return;
    end
    m_tick = 0; m_ack = 0;
    m_err = l && (d < 2);
    if (l && d >= 2) begin
      m_pend = d;
      m_pend_v = 1;
    end
    start = (!m_run && e) || (m_run && (m_p == m_n - 1) && e);
    stop  = m_run && (m_p == m_n - 1) && !e;
    if (start) begin
      if (m_pend_v) begin
        m_n = m_pend;
        m_pend_v = 0;
        m_ack = 1;
      end
      m_run = 1; m_p = 0; m_tick = 1;
    end else if (stop) begin
      m_run = 0; m_p = 0;
    end else if (m_run) begin
      m_p++;
    end
  endtask

  // One clk_i cycle: drive, clock, check both halves against the model
  task automatic step(input logic r, input logic e, input logic l, input logic [DIV_W-1:0] d);
    reset_i = r; en_i = e; div_load_i = l; div_i = d;
    @(posedge clk_i);
    model_edge(r, e, l, int'(d));
    #2;
    chk_bit("clk_o_hi_half0", clk_o, exp_clk(0));
    chk_bit("tick_o", tick_o, m_tick);
    chk_bit("div_ack_o", div_ack_o, m_ack);
    chk_bit("div_err_o", div_err_o, m_err);
`ifdef CLOCK_DIVIDER_N_PHASE_OUT_EN
    chk_int("phase_o", longint'(phase_o), longint'(m_run ? m_p : 0));
`endif
    if (div_ack_o === 1'b1) ack_cnt++;
    if (div_err_o === 1'b1) err_cnt++;
    if (tick_o === 1'b1) tick_cnt++;
    @(negedge clk_i);
    #2;
    chk_bit("clk_o_half1", clk_o, exp_clk(1));
  endtask

  task automatic go_idle();
    for (int i = 0; i < 600 && m_run; i++) step(1'b0, 1'b0, 1'b0, '0);
    if (m_run) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_wait @%0t: still running, expected idle", $time);
    end
  endtask

  task automatic load_idle(input int n);
    go_idle();
    step(1'b0, 1'b0, 1'b1, DIV_W'(n));
  endtask

  task automatic run_until(input int p);
    for (int i = 0; i < 600 && m_p != p; i++) step(1'b0, 1'b1, 1'b0, '0);
    if (m_p != p) begin
      n_chk++;
      n_fail++;
      $display("FAIL phase_wait @%0t: position %0d, expected %0d", $time, m_p, p);
    end
  endtask

  // Run enabled for ncyc cycles and measure the last full clk_o period and its high time
  task automatic measure(input int ncyc, output longint per, output longint hi);
    time r0;
    rises.delete();
    falls.delete();
    meas_on = 1'b1;
    repeat (ncyc) step(1'b0, 1'b1, 1'b0, '0);
    meas_on = 1'b0;
    per = 0;
    hi = 0;
    if (rises.size() >= 2) begin
      r0 = rises[rises.size() - 2];
      per = longint'(rises[rises.size() - 1] - r0);
      foreach (falls[i]) if (hi == 0 && falls[i] > r0) hi = longint'(falls[i] - r0);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog @%0t: simulation did not finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    longint per, hi;
    int a0, e0, t0;

    tbl[0] = '{2, 10, 20};
    tbl[1] = '{3, 15, 30};
    tbl[2] = '{4, 20, 40};
    tbl[3] = '{5, 25, 50};
    tbl[4] = '{6, 30, 60};
    tbl[5] = '{7, 35, 70};
    tbl[6] = '{8, 40, 80};
    tbl[7] = '{255, 1275, 2550};

    // Reset, then default divide-by-3
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    chk_bit("rst_clk_o", clk_o, 1'b0);
    chk_bit("rst_tick_o", tick_o, 1'b0);
    a0 = ack_cnt; e0 = err_cnt; t0 = tick_cnt;
    measure(12, per, hi);
    chk_int("def3_period", per, 30);
    chk_int("def3_high", hi, 15);
    chk_int("def3_ticks", tick_cnt - t0, 4);
    chk_int("def3_acks", ack_cnt - a0, 0);
    chk_int("def3_errs", err_cnt - e0, 0);

    // Divisor table: load in IDLE, enable, measure
    for (int i = 0; i < 8; i++) begin
      load_idle(tbl[i].div);
      a0 = ack_cnt;
      measure(2 * tbl[i].div + 6, per, hi);
      chk_int($sformatf("tbl_period_n%0d", tbl[i].div), per, tbl[i].per_ns);
      chk_int($sformatf("tbl_high_n%0d", tbl[i].div), hi, tbl[i].hi_ns);
      chk_int($sformatf("tbl_ack_n%0d", tbl[i].div), ack_cnt - a0, 1);
    end

    // Two loads inside one N=3 period: last wins, single ack
    load_idle(3);
    step(1'b0, 1'b1, 1'b0, '0);
    a0 = ack_cnt;
    step(1'b0, 1'b1, 1'b1, DIV_W'(6));
    step(1'b0, 1'b1, 1'b1, DIV_W'(5));
    step(1'b0, 1'b1, 1'b0, '0);
    measure(16, per, hi);
    chk_int("lastwin_period", per, 50);
    chk_int("lastwin_high", hi, 25);
    chk_int("lastwin_acks", ack_cnt - a0, 1);

    // Disable mid-period at N=4, then restart
    load_idle(4);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    repeat (8) step(1'b0, 1'b0, 1'b0, '0);
    chk_bit("stopped_clk_o", clk_o, 1'b0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk_bit("restart_clk_o", clk_o, 1'b1);
    chk_bit("restart_tick_o", tick_o, 1'b1);

    // Rejected loads leave N=4 timing intact
    e0 = err_cnt; a0 = ack_cnt;
    step(1'b0, 1'b1, 1'b1, DIV_W'(0));
    step(1'b0, 1'b1, 1'b1, DIV_W'(1));
    step(1'b0, 1'b1, 1'b0, '0);
    chk_int("badload_errs", err_cnt - e0, 2);
    measure(14, per, hi);
    chk_int("badload_period", per, 40);
    chk_int("badload_high", hi, 20);
    chk_int("badload_acks", ack_cnt - a0, 0);

    // Reset during the high phase at N=7
    load_idle(7);
    step(1'b0, 1'b1, 1'b0, '0);
    run_until(2);
    step(1'b1, 1'b1, 1'b0, '0);
    chk_bit("midrst_clk_o", clk_o, 1'b0);
    chk_bit("midrst_tick_o", tick_o, 1'b0);
    chk_bit("midrst_ack_o", div_ack_o, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0);
    measure(12, per, hi);
    chk_int("postrst_period", per, 30);
    chk_int("postrst_high", hi, 15);

    // Random enable/load/reset traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic r, e, l;
      logic [DIV_W-1:0] d;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 9) != 0);
      l = ($urandom_range(0, 5) == 0);
      d = ($urandom_range(0, 9) == 0) ? DIV_W'($urandom_range(0, 40)) : DIV_W'($urandom_range(0, 9));
      step(r, e, l, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
